// File: rtl/ysyx_24120013_inst_fetch.sv
// ysyx_24120013_inst_fetch: instruction fetch unit.
// Holds the PC, issues one instruction-memory request at a time and presents
// each fetched instruction with its PC to decode over a valid/ready handshake.
// A redirect from later stages reloads the PC and marks any in-flight response
// as stale so that it is discarded on arrival.
// Optional build macro YSYX_24120013_IFU_PERF_EN adds the perf_fetch_cnt and
// perf_stall_cnt performance counters; fetch behaviour is the same either way.
module ysyx_24120013_inst_fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    // redirect from later stages
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    // instruction memory request channel
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    // instruction memory response channel
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    // decode handshake
    output logic                  IFU_valid,
    input  logic                  IFU_ready,
    output logic [31:0]           IFU_inst,
`ifdef YSYX_24120013_IFU_PERF_EN
    output logic [ADDR_WIDTH-1:0] IFU_pc,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`else
    output logic [ADDR_WIDTH-1:0] IFU_pc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    drop_q;
    logic [31:0]             inst_q;
    logic [ADDR_WIDTH-1:0]   ifu_pc_q;
    logic [ADDR_WIDTH-1:0]   pc_plus4_d;

    // Sequential PC; the add wraps naturally at 2^ADDR_WIDTH.
    assign pc_plus4_d = pc_q + ADDR_WIDTH'(4);

    // Outputs are pure decodes of registered state, so they are glitch-free.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign IFU_valid      = (state_q == S_HOLD);
    assign IFU_inst       = inst_q;
    assign IFU_pc         = ifu_pc_q;

    // Fetch FSM: redirect has priority in every state and always reloads the PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            inst_q   <= '0;
            ifu_pc_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so pc_q read for ifu_pc_q is the fetch address.
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    state_q <= S_REQ;
                end

                S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    if (imem_req_ready) begin
                        // The old address was accepted; a redirect makes its
                        // response stale.
                        drop_q  <= redirect_valid;
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (imem_resp_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            inst_q   <= imem_resp_data;
                            ifu_pc_q <= pc_q;
                            state_q  <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // Decode may still take the held instruction during a
                    // redirect, but the redirect target replaces pc+4.
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= S_REQ;
                    end else if (IFU_ready) begin
                        pc_q    <= pc_plus4_d;
                        state_q <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef YSYX_24120013_IFU_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Performance counters: delivered instructions and cycles spent fetching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (IFU_valid && IFU_ready) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
